// File: rtl/gonso_io_sequencer_pkg.sv
// gonso_io_pkg: shared constants and types for the gonso IO sequencer.
//   - Register byte offsets inside the Wishbone window
//   - CTRL bit positions and the mask of CTRL bits that are actually stored
//   - Sequencer FSM state encoding
//   - Reset value of the output-enable-bar register
//   - Byte-lane merge helper used by every writable register
package gonso_io_pkg;

   localparam logic [7:0] CTRL_OFS     = 8'h00;
   localparam logic [7:0] STATUS_OFS   = 8'h04;
   localparam logic [7:0] DIRECT_OFS   = 8'h08;
   localparam logic [7:0] OEB_OFS      = 8'h0C;
   localparam logic [7:0] PAT_BASE_OFS = 8'h10;

   localparam int CTRL_START_BIT = 0;
   localparam int CTRL_STOP_BIT  = 1;
   localparam int CTRL_LOOP_BIT  = 2;
   localparam int CTRL_LAST_LSB  = 4;
   localparam int CTRL_LAST_MSB  = 7;

   // START/STOP are pulses, so only LOOP and LAST are kept in the register
   localparam logic [31:0] CTRL_MASK   = 32'h0000_00F4;
   localparam logic [31:0] OEB_DEFAULT = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } seq_state_e;

   // Merge new_w into old_w on the byte lanes selected by sel
   function automatic logic [31:0] apply_sel(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  sel);
      logic [31:0] lane_mask;
      for (int b = 0; b < 4; b++) begin
         lane_mask[8*b +: 8] = {8{sel[b]}};
      end
      return (old_w & ~lane_mask) | (new_w & lane_mask);
   endfunction

endpackage

// File: rtl/gonso_io_sequencer_if.sv
// gonso_io_sequencer_if: Wishbone slave bus between the management SoC and
// the IO sequencer.
//   master modport: drives cyc/stb/we/sel/adr/dat_i, receives ack/dat_o
//   slave  modport: the register block side
interface gonso_io_sequencer_if;
   logic        wbs_cyc_i;
   logic        wbs_stb_i;
   logic        wbs_we_i;
   logic [3:0]  wbs_sel_i;
   logic [31:0] wbs_adr_i;
   logic [31:0] wbs_dat_i;
   logic        wbs_ack_o;
   logic [31:0] wbs_dat_o;

   modport master (
      output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
      input  wbs_ack_o, wbs_dat_o
   );

   modport slave (
      input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
      output wbs_ack_o, wbs_dat_o
   );
endinterface

// File: rtl/gonso_io_sequencer_wb_regs.sv
// gonso_wb_regs: Wishbone decode, single-cycle ack, register file and
// byte-lane writes for the IO sequencer.
//   clock, resetb            : user clock, async active-low reset
//   wbs                      : Wishbone slave bus
//   busy_i, done_i, idx_i    : sequencer status for the STATUS register
//   start_o, stop_o          : one-cycle pulses from CTRL writes
//   loop_o, last_o           : stored CTRL fields
//   direct_o, oeb_o          : DIRECT and OEB registers
//   pat_value_o, pat_hold_o  : per-entry pattern fields
// Misaligned addresses (adr[1:0] != 0) are treated as unmapped.
module gonso_wb_regs
   import gonso_io_pkg::*;
#(
   parameter int          IO_W      = 8,
   parameter int          DEPTH     = 8,
   parameter int          HOLD_W    = 16,
   parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
   input  logic                          clock,
   input  logic                          resetb,
   gonso_io_sequencer_if.slave           wbs,
   input  logic                          busy_i,
   input  logic                          done_i,
   input  logic [3:0]                    idx_i,
   output logic                          start_o,
   output logic                          stop_o,
   output logic                          loop_o,
   output logic [3:0]                    last_o,
   output logic [IO_W-1:0]               direct_o,
   output logic [IO_W-1:0]               oeb_o,
   output logic [DEPTH-1:0][IO_W-1:0]    pat_value_o,
   output logic [DEPTH-1:0][HOLD_W-1:0]  pat_hold_o
);

   localparam int          IDX_W       = $clog2(DEPTH);
   localparam logic [31:0] VAL_MASK    = 32'((64'd1 << IO_W) - 64'd1);
   localparam logic [31:0] HOLD_MASK   = 32'(((64'd1 << HOLD_W) - 64'd1) << 8);
   localparam logic [31:0] PAT_MASK    = VAL_MASK | HOLD_MASK;
   localparam logic [5:0]  PAT_FIRST_W = PAT_BASE_OFS[7:2];
   localparam logic [5:0]  PAT_END_W   = 6'(int'(PAT_BASE_OFS[7:2]) + DEPTH);

   logic                   ack_r;
   logic                   start_r;
   logic                   stop_r;
   logic [31:0]            dat_r;
   logic [31:0]            ctrl_r;
   logic [31:0]            direct_r;
   logic [31:0]            oeb_r;
   logic [DEPTH-1:0][31:0] pat_r;

   logic                   req_s;
   logic                   hit_s;
   logic                   is_pat_s;
   logic [5:0]             word_s;
   logic [IDX_W-1:0]       pat_idx_s;
   logic [31:0]            rdata_s;
   logic [31:0]            merged_s;

   // Request qualification and address decode
   always_comb begin
      req_s     = wbs.wbs_cyc_i & wbs.wbs_stb_i & ~ack_r;
      hit_s     = (wbs.wbs_adr_i[31:8] == BASE_ADDR[31:8]) && (wbs.wbs_adr_i[1:0] == 2'b00);
      word_s    = wbs.wbs_adr_i[7:2];
      is_pat_s  = hit_s && (word_s >= PAT_FIRST_W) && (word_s < PAT_END_W);
      pat_idx_s = IDX_W'(word_s - PAT_FIRST_W);
   end

   // Read multiplexer; anything unmapped reads as zero
   always_comb begin
      rdata_s = 32'h0000_0000;
      if (!hit_s) begin
         rdata_s = 32'h0000_0000;
      end else if (is_pat_s) begin
         rdata_s = pat_r[pat_idx_s];
      end else begin
         case (word_s)
            CTRL_OFS[7:2]:   rdata_s = ctrl_r;
            STATUS_OFS[7:2]: rdata_s = {24'h00_0000, idx_i, 2'b00, done_i, busy_i};
            DIRECT_OFS[7:2]: rdata_s = direct_r;
            OEB_OFS[7:2]:    rdata_s = oeb_r;
            default:         rdata_s = 32'h0000_0000;
         endcase
      end
   end

   // Byte-lane merge of the write data into the addressed register
   always_comb begin
      merged_s = 32'h0000_0000;
      if (is_pat_s) begin
         merged_s = apply_sel(pat_r[pat_idx_s], wbs.wbs_dat_i, wbs.wbs_sel_i);
      end else begin
         case (word_s)
            CTRL_OFS[7:2]:   merged_s = apply_sel(ctrl_r,   wbs.wbs_dat_i, wbs.wbs_sel_i);
            DIRECT_OFS[7:2]: merged_s = apply_sel(direct_r, wbs.wbs_dat_i, wbs.wbs_sel_i);
            OEB_OFS[7:2]:    merged_s = apply_sel(oeb_r,    wbs.wbs_dat_i, wbs.wbs_sel_i);
            default:         merged_s = 32'h0000_0000;
         endcase
      end
   end

   // Ack/read-data pipeline, CTRL pulses and register writes
   always_ff @(posedge clock or negedge resetb) begin
      if (!resetb) begin
         ack_r    <= 1'b0;
         start_r  <= 1'b0;
         stop_r   <= 1'b0;
         dat_r    <= 32'h0000_0000;
         ctrl_r   <= 32'h0000_0000;
         direct_r <= 32'h0000_0000;
         oeb_r    <= OEB_DEFAULT & VAL_MASK;
         pat_r    <= {(DEPTH*32){1'b0}};
      end else begin
         ack_r   <= req_s;
         start_r <= 1'b0;
         stop_r  <= 1'b0;
         // read data lives only in the ack cycle
         if (req_s && !wbs.wbs_we_i) begin
            dat_r <= rdata_s;
         end else begin
            dat_r <= 32'h0000_0000;
         end
         if (req_s && wbs.wbs_we_i && hit_s) begin
            if (is_pat_s) begin
               pat_r[pat_idx_s] <= merged_s & PAT_MASK;
            end else begin
               case (word_s)
                  CTRL_OFS[7:2]: begin
                     ctrl_r  <= merged_s & CTRL_MASK;
                     start_r <= wbs.wbs_sel_i[0] & wbs.wbs_dat_i[CTRL_START_BIT];
                     stop_r  <= wbs.wbs_sel_i[0] & wbs.wbs_dat_i[CTRL_STOP_BIT];
                  end
                  DIRECT_OFS[7:2]: direct_r <= merged_s & VAL_MASK;
                  OEB_OFS[7:2]:    oeb_r    <= merged_s & VAL_MASK;
                  default: begin
                  end
               endcase
            end
         end
      end
   end

   assign wbs.wbs_ack_o = ack_r;
   assign wbs.wbs_dat_o = dat_r;
   assign start_o       = start_r;
   assign stop_o        = stop_r;
   assign loop_o        = ctrl_r[CTRL_LOOP_BIT];
   assign last_o        = ctrl_r[CTRL_LAST_MSB:CTRL_LAST_LSB];
   assign direct_o      = direct_r[IO_W-1:0];
   assign oeb_o         = oeb_r[IO_W-1:0];

   for (genvar i = 0; i < DEPTH; i++) begin : g_pat
      assign pat_value_o[i] = pat_r[i][IO_W-1:0];
      assign pat_hold_o[i]  = pat_r[i][8+HOLD_W-1:8];
   end

endmodule

// File: rtl/gonso_io_sequencer.sv
// gonso_io_sequencer: owns mprj_io[IO_W-1:0]. Drives either the firmware
// DIRECT value or a timed (value, hold) pattern played by the sequencer.
//   clock, resetb     : user clock, async active-low reset
//   wbs               : Wishbone slave bus (register window at BASE_ADDR)
//   io_out            : value driven onto the IO bank
//   io_oeb            : output-enable bar per bit (1 = input)
//   busy_o / done_o   : sequencer in RUN / DONE
module gonso_io_sequencer
   import gonso_io_pkg::*;
#(
   parameter int          IO_W      = 8,
   parameter int          DEPTH     = 8,
   parameter int          HOLD_W    = 16,
   parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
   input  logic                clock,
   input  logic                resetb,
   gonso_io_sequencer_if.slave wbs,
   output logic [IO_W-1:0]     io_out,
   output logic [IO_W-1:0]     io_oeb,
   output logic                busy_o,
   output logic                done_o
);

   localparam int               IDX_W   = $clog2(DEPTH);
   localparam logic [4:0]       DEPTH_C = 5'(DEPTH);
   localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(DEPTH - 1);
   localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);
   localparam logic [HOLD_W-1:0] CNT_ONE = HOLD_W'(1);

   logic                         start_s;
   logic                         stop_s;
   logic                         loop_s;
   logic [3:0]                   last_s;
   logic [IO_W-1:0]              direct_s;
   logic [IO_W-1:0]              oeb_s;
   logic [DEPTH-1:0][IO_W-1:0]   pat_value_s;
   logic [DEPTH-1:0][HOLD_W-1:0] pat_hold_s;

   seq_state_e                   state_r;
   seq_state_e                   state_next_s;
   logic [IDX_W-1:0]             idx_r;
   logic [IDX_W-1:0]             idx_next_s;
   logic [IDX_W-1:0]             idx_inc_s;
   logic [IDX_W-1:0]             last_eff_s;
   logic [HOLD_W-1:0]            cnt_r;
   logic [HOLD_W-1:0]            cnt_next_s;
   logic                         load_s;
   logic [IO_W-1:0]              io_out_r;
   logic                         busy_r;
   logic                         done_r;

   gonso_wb_regs #(
      .IO_W      (IO_W),
      .DEPTH     (DEPTH),
      .HOLD_W    (HOLD_W),
      .BASE_ADDR (BASE_ADDR)
   ) u_regs (
      .clock       (clock),
      .resetb      (resetb),
      .wbs         (wbs),
      .busy_i      (busy_r),
      .done_i      (done_r),
      .idx_i       (4'(idx_r)),
      .start_o     (start_s),
      .stop_o      (stop_s),
      .loop_o      (loop_s),
      .last_o      (last_s),
      .direct_o    (direct_s),
      .oeb_o       (oeb_s),
      .pat_value_o (pat_value_s),
      .pat_hold_o  (pat_hold_s)
   );

   // LAST beyond the table is clamped to the final entry
   always_comb begin
      idx_inc_s = idx_r + IDX_ONE;
      if ({1'b0, last_s} >= DEPTH_C) begin
         last_eff_s = IDX_MAX;
      end else begin
         last_eff_s = last_s[IDX_W-1:0];
      end
   end

   // Sequencer next-state; load_s marks the cycle a new entry is latched
   always_comb begin
      state_next_s = state_r;
      idx_next_s   = idx_r;
      cnt_next_s   = cnt_r;
      load_s       = 1'b0;
      case (state_r)
         ST_IDLE: begin
            idx_next_s = {IDX_W{1'b0}};
            cnt_next_s = {HOLD_W{1'b0}};
            // STOP has priority when both pulses arrive together
            if (start_s && !stop_s) begin
               state_next_s = ST_RUN;
               cnt_next_s   = pat_hold_s[0];
               load_s       = 1'b1;
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (stop_s) begin
               state_next_s = ST_IDLE;
               idx_next_s   = {IDX_W{1'b0}};
               cnt_next_s   = {HOLD_W{1'b0}};
            end else if (cnt_r <= CNT_ONE) begin
               // hold of 0 or 1 both end the entry after one cycle
               if (idx_r < last_eff_s) begin
                  idx_next_s = idx_inc_s;
                  cnt_next_s = pat_hold_s[idx_inc_s];
                  load_s     = 1'b1;
               end else if (loop_s) begin
                  idx_next_s = {IDX_W{1'b0}};
                  cnt_next_s = pat_hold_s[0];
                  load_s     = 1'b1;
               end else begin
                  state_next_s = ST_DONE;
               end
            end else begin
               cnt_next_s = cnt_r - CNT_ONE;
            end
         end
         ST_DONE: begin
            if (stop_s) begin
               state_next_s = ST_IDLE;
               idx_next_s   = {IDX_W{1'b0}};
               cnt_next_s   = {HOLD_W{1'b0}};
            end else if (start_s) begin
               state_next_s = ST_RUN;
               idx_next_s   = {IDX_W{1'b0}};
               cnt_next_s   = pat_hold_s[0];
               load_s       = 1'b1;
            end else begin
               state_next_s = ST_DONE;
            end
         end
         default: begin
            state_next_s = ST_IDLE;
            idx_next_s   = {IDX_W{1'b0}};
            cnt_next_s   = {HOLD_W{1'b0}};
         end
      endcase
   end

   // State, counters and registered outputs. The pattern value is latched
   // only on entry load so rewrites of PAT mid-entry do not glitch io_out.
   always_ff @(posedge clock or negedge resetb) begin
      if (!resetb) begin
         state_r  <= ST_IDLE;
         idx_r    <= {IDX_W{1'b0}};
         cnt_r    <= {HOLD_W{1'b0}};
         io_out_r <= {IO_W{1'b0}};
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
      end else begin
         state_r <= state_next_s;
         idx_r   <= idx_next_s;
         cnt_r   <= cnt_next_s;
         busy_r  <= (state_next_s == ST_RUN);
         done_r  <= (state_next_s == ST_DONE);
         if (state_next_s == ST_IDLE) begin
            io_out_r <= direct_s;
         end else if (load_s) begin
            io_out_r <= pat_value_s[idx_next_s];
         end
      end
   end

   assign io_out = io_out_r;
   assign io_oeb = oeb_s;
   assign busy_o = busy_r;
   assign done_o = done_r;

endmodule
